// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sched
// Purpose  : Multiply/divide sequencer for the E stage of the MIPS pipeline.
//            It owns the HI/LO pair and accepts one mult/multu/div/divu/mthi/
//            mtlo per start pulse. The result of a mult or div is computed at
//            the start edge, held in a pending register and committed to HI/LO
//            only when the busy window ends. During that window a stall
//            request is raised when the D-stage instruction needs the unit.
// Ports    : clk          rising-edge clock
//            reset        asynchronous active-high reset, clears all state
//            i_start      E-stage instruction is an MDU op this cycle
//            i_md_op      000 mult, 001 multu, 010 div, 011 divu,
//                         100 mthi, 101 mtlo, 11x reserved (ignored)
//            i_a, i_b     forwarded rs / rt operands
//            i_d_md_use   D-stage instruction uses the MDU or HI/LO
//            o_hi, o_lo   HI / LO registers
//            o_busy       a mult/div result is pending (registered)
//            o_stall_req  combinational stall request to the hazard unit
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_d_md_use,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_stall_req
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [31:0]         r_pend_hi;
  logic [31:0]         r_pend_lo;
  logic                r_pend_wr;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic                r_busy;

  logic [63:0] w_prod;
  logic        w_div_signed;
  logic        w_b_zero;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_md_type;

  // Product: sign-extending both operands to 64 bits gives the correct signed
  // result in the low 64 bits of the product.
  always_comb begin
    w_prod = '0;
    if (i_md_op[0]) begin
      w_prod = {32'd0, i_a} * {32'd0, i_b};
    end else begin
      w_prod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    end
  end

  // Division on magnitudes, then sign fix-up: quotient negative when the
  // operand signs differ, remainder follows the dividend. This also yields
  // 0x80000000 / -1 = 0x80000000 rem 0 without a special case. A zero
  // divisor is replaced by 1 so the divider never sees it; the result is
  // discarded at commit anyway.
  always_comb begin
    w_div_signed = (i_md_op == c_OP_DIV);
    w_b_zero     = (i_b == 32'd0);
    w_a_neg      = w_div_signed & i_a[31];
    w_b_neg      = w_div_signed & i_b[31];
    w_a_mag      = w_a_neg ? (32'd0 - i_a) : i_a;
    w_b_mag      = w_b_zero ? 32'd1 : (w_b_neg ? (32'd0 - i_b) : i_b);
    w_q_mag      = w_a_mag / w_b_mag;
    w_r_mag      = w_a_mag % w_b_mag;
    w_quo        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  end

  assign w_md_type = i_start & ~i_md_op[2];

  // The last busy cycle needs no stall: the commit happens on the same edge
  // that advances the D-stage instruction into E, so it sees the new HI/LO.
  assign o_stall_req = i_d_md_use & ((r_busy & (r_cnt != c_CNT_ONE)) | w_md_type);

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            case (i_md_op)
              c_OP_MULT, c_OP_MULTU: begin
                {r_pend_hi, r_pend_lo} <= w_prod;
                r_pend_wr <= 1'b1;
                r_cnt     <= c_MULT_CNT;
                r_busy    <= 1'b1;
                r_state   <= S_RUN;
              end
              c_OP_DIV, c_OP_DIVU: begin
                r_pend_hi <= w_rem;
                r_pend_lo <= w_quo;
                r_pend_wr <= ~w_b_zero;
                r_cnt     <= c_DIV_CNT;
                r_busy    <= 1'b1;
                r_state   <= S_RUN;
              end
              c_OP_MTHI: r_hi <= i_a;
              c_OP_MTLO: r_lo <= i_a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // Any start arriving here is dropped.
          if (r_cnt == c_CNT_ONE) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sched
// Purpose  : Self-checking bench for mdu_sched. A reference model tracks the
//            expected HI/LO, busy and stall_req per cycle from the operation
//            rules (plain 64-bit arithmetic and a commit-edge timestamp);
//            a vector table adds fixed expected results and window lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_md_op = 3'd0;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic        i_d_md_use = 1'b0;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_stall_req;

  mdu_sched #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_md_op     (i_md_op),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_d_md_use  (i_d_md_use),
    .o_hi        (o_hi),
    .o_lo        (o_lo),
    .o_busy      (o_busy),
    .o_stall_req (o_stall_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_busy_seen = 0;
  int n_stall_seen = 0;

  // Reference model state: architectural HI/LO plus the pending result and
  // the edge number on which it commits.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  bit          m_pwr = 1'b0;
  bit          m_pend = 1'b0;
  int          m_commit = 0;
  int          m_edge = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output bit wr);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = 32'd0;
    lo = 32'd0;
    wr = 1'b1;
    case (op)
      3'd0: begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
      3'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin p = ua / ub; lo = p[31:0]; p = ua % ub; hi = p[31:0]; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model across the rising edge. Entered and left at posedge+1.
  task automatic cycle(input logic s, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic du);
    logic exp_stall;
    i_start    = s;
    i_md_op    = op;
    i_a        = a;
    i_b        = b;
    i_d_md_use = du;
    #1;
    exp_stall = du && ((m_pend && (m_edge < m_commit - 1)) || (s && !op[2]));
    chk("busy", {31'd0, o_busy}, {31'd0, m_pend});
    chk("stall_req", {31'd0, o_stall_req}, {31'd0, exp_stall});
    chk("hi", o_hi, m_hi);
    chk("lo", o_lo, m_lo);
    if (o_busy) n_busy_seen++;
    if (o_stall_req) n_stall_seen++;
    @(posedge clk);
    #1;
    m_edge++;
    if (m_pend) begin
      if (m_edge == m_commit) begin
        if (m_pwr) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
        m_pend = 1'b0;
      end
    end else if (s) begin
      if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
      else if (!op[2]) begin
        ref_op(op, a, b, m_phi, m_plo, m_pwr);
        m_pend   = 1'b1;
        m_commit = m_edge + (op[1] ? DIV_CYCLES : MULT_CYCLES);
      end
    end
  endtask

  task automatic idle(input int n, input logic du);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'd0, 32'd0, 32'd0, du);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat = v.op[1] ? DIV_CYCLES : MULT_CYCLES;
    cycle(1'b1, 3'd4, v.pre_hi, 32'd0, 1'b0);
    cycle(1'b1, 3'd5, v.pre_lo, 32'd0, 1'b0);
    n_busy_seen  = 0;
    n_stall_seen = 0;
    cycle(1'b1, v.op, v.a, v.b, 1'b1);
    idle(lat + 2, 1'b1);
    chk($sformatf("vec%0d busy_cycles", idx), n_busy_seen, lat);
    chk($sformatf("vec%0d stall_cycles", idx), n_stall_seen, lat);
    chk($sformatf("vec%0d hi", idx), o_hi, v.exp_hi);
    chk($sformatf("vec%0d lo", idx), o_lo, v.exp_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic        rs;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        rdu;

    vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'd7,        32'd0,        32'h11, 32'h22, 32'h11,       32'h22};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  32'h0,        32'h80000000};
    vecs[5] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'h1,        32'hFFFFFFFD};
    vecs[6] = '{3'd3, 32'hFFFFFFFF, 32'h10,       32'h0,  32'h0,  32'hF,        32'h0FFFFFFF};
    vecs[7] = '{3'd2, 32'd0,        32'd0,        32'hAA, 32'hBB, 32'hAA,       32'hBB};
    vecs[8] = '{3'd0, 32'h80000000, 32'h80000000, 32'h0,  32'h0,  32'h40000000, 32'h0};
    vecs[9] = '{3'd1, 32'h12345678, 32'd0,        32'h1,  32'h2,  32'h0,        32'h0};

    // Reset values.
    @(posedge clk);
    #1;
    chk("reset hi", o_hi, 32'd0);
    chk("reset lo", o_lo, 32'd0);
    chk("reset busy", {31'd0, o_busy}, 32'd0);
    chk("reset stall", {31'd0, o_stall_req}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Starts (mult and mthi) during RUN are ignored.
    cycle(1'b1, 3'd2, 32'd100, 32'd7, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 3'd0, 32'd5, 32'd5, 1'b1);
    cycle(1'b1, 3'd4, 32'hDEAD, 32'd0, 1'b1);
    idle(9, 1'b1);
    chk("ignore hi", o_hi, 32'd2);
    chk("ignore lo", o_lo, 32'd14);

    // Back-to-back: new start accepted on the cycle after busy falls.
    cycle(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
    idle(MULT_CYCLES, 1'b0);
    cycle(1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
    chk("b2b busy", {31'd0, o_busy}, 32'd1);
    idle(MULT_CYCLES + 1, 1'b0);
    chk("b2b hi", o_hi, 32'd0);
    chk("b2b lo", o_lo, 32'd42);

    // mthi then mtlo with D-stage MDU use: no stall. Then reset mid-div.
    cycle(1'b1, 3'd4, 32'h55, 32'd0, 1'b1);
    cycle(1'b1, 3'd5, 32'h66, 32'd0, 1'b1);
    cycle(1'b1, 3'd2, 32'd1000, 32'd3, 1'b0);
    idle(3, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst busy", {31'd0, o_busy}, 32'd0);
    chk("midrst hi", o_hi, 32'd0);
    chk("midrst lo", o_lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_pend = 1'b0; m_pwr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_busy_seen = 0;
    cycle(1'b1, 3'd0, 32'd7, 32'd9, 1'b0);
    idle(MULT_CYCLES + 2, 1'b0);
    chk("postrst busy_cycles", n_busy_seen, MULT_CYCLES);
    chk("postrst hi", o_hi, 32'd0);
    chk("postrst lo", o_lo, 32'd63);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rs  = ($urandom_range(0, 2) == 0);
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: rb = $urandom;
      endcase
      rdu = 1'($urandom_range(0, 1));
      cycle(rs, rop, ra, rb, rdu);
    end
    idle(DIV_CYCLES + 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
